// File: rtl/branch_pkg.sv
// branch_pkg: shared encodings for the execute-stage branch resolution unit
package branch_pkg;
  localparam int DEF_WIDTH = 32;
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_BEQ  = 2'b01;
  localparam logic [1:0] OP_BNE  = 2'b10;
  localparam logic [1:0] OP_JMP  = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_REDIRECT, ST_FLUSH} state_t;
endpackage

// File: rtl/branch_cond_eval.sv
// branch_cond_eval: combinational branch condition and shifted target adder
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_valid,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_pc4,
  input  logic [WIDTH-1:0] i_imm,
  input  logic [WIDTH-1:0] i_rs,
  input  logic [WIDTH-1:0] i_rt,
  output logic             o_taken,
  output logic [WIDTH-1:0] o_target
);
  logic w_eq;
  logic w_cond;
  // offset is in words, so shift left by two before adding; wraps modulo 2^WIDTH
  always_comb begin
    w_eq     = i_rs == i_rt;
    w_cond   = (i_op == OP_NONE) ? 1'b0 :
               (i_op == OP_BEQ)  ? w_eq :
               (i_op == OP_BNE)  ? !w_eq : 1'b1;
    o_taken  = i_valid & w_cond;
    o_target = i_pc4 + (i_imm << 2);
  end
endmodule

// File: rtl/branch_resolve_ex.sv
// branch_resolve_ex: EX-stage branch resolution with redirect/flush state machine
module branch_resolve_ex
  import branch_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             valid_in,
  input  logic             stall_in,
  input  logic [1:0]       branch_op,
  input  logic [WIDTH-1:0] entradaPC4,
  input  logic [WIDTH-1:0] imm_in,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             PCSrc,
  output logic [WIDTH-1:0] sinal_deslocado,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             busy
);
  state_t           r_state;
  logic [2:0]       r_cnt;
  logic             r_pcsrc;
  logic             r_flush;
  logic             r_busy;
  logic [WIDTH-1:0] r_target;
  logic             w_taken;
  logic [WIDTH-1:0] w_target;

  branch_cond_eval #(.WIDTH(WIDTH)) u_eval (
    .i_valid  (valid_in),
    .i_op     (branch_op),
    .i_pc4    (entradaPC4),
    .i_imm    (imm_in),
    .i_rs     (rs_val),
    .i_rt     (rt_val),
    .o_taken  (w_taken),
    .o_target (w_target)
  );

  // redirect for one cycle, then squash for the remaining flush cycles; wrong-path branches are ignored while busy
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_pcsrc  <= 1'b0;
      r_flush  <= 1'b0;
      r_busy   <= 1'b0;
      r_target <= '0;
    end else if (!stall_in) begin
      case (r_state)
        ST_IDLE: if (w_taken) begin
          r_state  <= ST_REDIRECT;
          r_target <= w_target;
          r_cnt    <= 3'(FLUSH_CYCLES - 1);
          r_pcsrc  <= 1'b1;
          r_flush  <= 1'b1;
          r_busy   <= 1'b1;
        end
        ST_REDIRECT: begin
          r_pcsrc <= 1'b0;
          if (r_cnt != 3'd0) begin
            r_state <= ST_FLUSH;
            r_cnt   <= r_cnt - 3'd1;
          end else begin
            r_state <= ST_IDLE;
            r_flush <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        ST_FLUSH: if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
        else begin
          r_state <= ST_IDLE;
          r_flush <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // outputs come straight from registers
  always_comb begin
    PCSrc           = r_pcsrc;
    sinal_deslocado = r_target;
    flush_ifid      = r_flush;
    flush_idex      = r_flush;
    busy            = r_busy;
  end
endmodule

// File: tb/tb_branch_resolve_ex.sv
// tb_branch_resolve_ex: scoreboard bench for branch_resolve_ex
module tb_branch_resolve_ex;
  localparam int FC = 2;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic        stall_in = 1'b0;
  logic [1:0]  branch_op = 2'b00;
  logic [31:0] entradaPC4 = '0, imm_in = '0, rs_val = '0, rt_val = '0;
  logic        PCSrc, flush_ifid, flush_idex, busy;
  logic [31:0] sinal_deslocado;

  typedef struct packed {
    logic        pcsrc;
    logic [31:0] tgt;
    logic        fi;
    logic        fx;
    logic        busy;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0, failures = 0, pulses = 0;
  int          m_rem = 0;
  logic [31:0] m_tgt = '0;

  branch_resolve_ex #(.WIDTH(32), .FLUSH_CYCLES(FC)) dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .stall_in(stall_in),
    .branch_op(branch_op), .entradaPC4(entradaPC4), .imm_in(imm_in),
    .rs_val(rs_val), .rt_val(rt_val), .PCSrc(PCSrc),
    .sinal_deslocado(sinal_deslocado), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic v, input logic st, input logic [1:0] op,
                      input logic [31:0] pc4, input logic [31:0] imm,
                      input logic [31:0] rs, input logic [31:0] rt);
    exp_t e;
    logic tk;
    @(negedge clock);
    reset = rst; valid_in = v; stall_in = st; branch_op = op;
    entradaPC4 = pc4; imm_in = imm; rs_val = rs; rt_val = rt;
    tk = v && (op == 2'b11 || (op == 2'b01 && rs == rt) || (op == 2'b10 && rs != rt));
    if (rst) begin
      m_rem = 0;
      m_tgt = '0;
    end else if (!st) begin
      if (m_rem == 0) begin
        if (tk) begin
          m_rem = FC;
          m_tgt = pc4 + imm * 32'd4;
        end
      end else m_rem = m_rem - 1;
    end
    e.pcsrc = (m_rem == FC);
    e.tgt   = m_tgt;
    e.fi    = (m_rem != 0);
    e.fx    = (m_rem != 0);
    e.busy  = (m_rem != 0);
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check("PCSrc", 32'(PCSrc), 32'(e.pcsrc));
    check("target", sinal_deslocado, e.tgt);
    check("flush_ifid", 32'(flush_ifid), 32'(e.fi));
    check("flush_idex", 32'(flush_idex), 32'(e.fx));
    check("busy", 32'(busy), 32'(e.busy));
    if (PCSrc) pulses++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask

  initial begin
    step(1, 0, 0, 2'b00, 0, 0, 0, 0);
    step(1, 0, 0, 2'b00, 0, 0, 0, 0);
    idle(1);
    step(0, 1, 0, 2'b01, 32'h100, 32'h10, 5, 5);
    idle(3);
    step(0, 1, 0, 2'b10, 32'h200, 32'h4, 7, 7);
    idle(1);
    step(0, 1, 0, 2'b10, 32'h200, 32'h4, 7, 8);
    idle(2);
    step(0, 1, 0, 2'b11, 32'h8, 32'hFFFF_FFFF, 0, 0);
    check("neg_target", sinal_deslocado, 32'h4);
    idle(2);
    step(0, 1, 0, 2'b11, 32'hFFFF_FFFC, 32'h1, 0, 0);
    check("wrap_target", sinal_deslocado, 32'h0);
    idle(2);
    step(0, 0, 0, 2'b11, 32'h300, 32'h1, 0, 0);
    step(0, 1, 0, 2'b00, 32'h300, 32'h1, 0, 0);
    pulses = 0;
    step(0, 1, 0, 2'b11, 32'h1000, 32'h8, 0, 0);
    step(0, 1, 0, 2'b11, 32'h2000, 32'h3, 0, 0);
    step(0, 1, 0, 2'b11, 32'h3000, 32'h5, 0, 0);
    idle(2);
    check("wrong_path_pulses", pulses, 1);
    check("wrong_path_target", sinal_deslocado, 32'h1020);
    step(0, 1, 0, 2'b11, 32'h400, 32'h2, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 2'b11, 32'h900, 32'h9, 0, 0);
    idle(3);
    step(0, 1, 0, 2'b11, 32'h500, 32'h1, 0, 0);
    idle(1);
    step(1, 1, 1, 2'b11, 32'h600, 32'h1, 0, 0);
    step(1, 1, 0, 2'b11, 32'h600, 32'h1, 0, 0);
    idle(2);
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
           2'($urandom_range(0, 3)), $urandom, $urandom,
           32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)));
    if (sb.size() != 0) check("scoreboard_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_resolve_ex.md
Name: branch_resolve_ex

Overview:
- Execute-stage branch resolution unit. It is the producer side of the fetch-stage PC select mux.
- Evaluates branch/jump conditions and computes the shifted target (PC+4 + (imm << 2)).
- Drives PCSrc and sinal_deslocado to the fetch mux, plus flush strobes to the IF/ID and ID/EX pipeline registers.
- Holds a small redirect/flush state machine so wrong-path instructions are squashed for a fixed number of cycles.

Parameters:
- WIDTH, 32, datapath and PC width.
- FLUSH_CYCLES, 2, cycles of flush after a taken branch, including the redirect cycle; legal range 1..7.

Ports:
- clock  input  1  single system clock, rising edge only.
- reset  input  1  synchronous, active-high reset.
- valid_in  input  1  instruction in EX is valid (not a bubble).
- stall_in  input  1  pipeline stall; freezes state and outputs.
- branch_op  input  2  00 none, 01 BEQ, 10 BNE, 11 JMP (unconditional).
- entradaPC4  input  WIDTH  PC+4 of the EX instruction.
- imm_in  input  WIDTH  sign-extended offset, in words.
- rs_val  input  WIDTH  first compare operand.
- rt_val  input  WIDTH  second compare operand.
- PCSrc  output  1  1 = fetch takes sinal_deslocado; 0 = fetch takes PC+4.
- sinal_deslocado  output  WIDTH  registered branch target.
- flush_ifid  output  1  squash the IF/ID register this cycle.
- flush_idex  output  1  squash the ID/EX register this cycle.
- busy  output  1  state machine is not in IDLE.

Behaviour:
- Clock and reset: one clock, `clock`. Reset is synchronous and active-high on `reset`. All state updates on the rising edge only.
- Reset values: state=IDLE, PCSrc=0, sinal_deslocado=0, flush_ifid=0, flush_idex=0, busy=0, counter=0.
- Target arithmetic:
  - target = entradaPC4 + {imm_in[WIDTH-3:0], 2'b00}, modulo 2^WIDTH.
  - Overflow wraps silently; no exception.
- Taken condition:
  - taken = valid_in & ((op==BEQ & rs==rt) | (op==BNE & rs!=rt) | op==JMP).
  - op==00 never takes.
- Latency: 1 cycle. A taken decision sampled at edge N produces PCSrc=1 and a valid sinal_deslocado in the cycle following edge N.
- FSM states: IDLE, REDIRECT, FLUSH.
- IDLE:
  - If !stall_in & taken -> REDIRECT. Register target into sinal_deslocado. Load counter=FLUSH_CYCLES-1.
  - Otherwise stay; PCSrc=0.
- REDIRECT (exactly one cycle unless stalled):
  - PCSrc=1, flush_ifid=1, flush_idex=1, busy=1.
  - Next state: FLUSH if counter>0, else IDLE.
- FLUSH:
  - PCSrc=0, flush_ifid=1, flush_idex=1, busy=1.
  - Counter decrements each unstalled cycle; when counter reaches 0 -> IDLE.
- Wrong-path suppression: while busy, valid_in/branch_op are ignored. A branch on the wrong path must never redirect.
- Stall:
  - stall_in=1 holds state, counter and all outputs unchanged.
  - sinal_deslocado stays stable for the whole stall.
- Reset mid-operation: reset dominates stall and any state. Next cycle all outputs are at reset values and any pending redirect is dropped.
- sinal_deslocado holds its last value in IDLE; it is only meaningful when PCSrc=1.
- FLUSH_CYCLES=1: REDIRECT returns directly to IDLE; FLUSH is never entered.

Decomposition:
- Shared package branch_pkg:
  - branch_op encoding constants (OP_NONE, OP_BEQ, OP_BNE, OP_JMP).
  - FSM state encoding.
  - WIDTH default.
- One natural sub-module, branch_cond_eval: combinational compare plus target adder, producing taken and target.
- The top level holds the FSM, counter and output registers.

Test Plan:
- Reset: hold reset 2 cycles mid-FLUSH -> all outputs 0, busy=0, state IDLE on the following cycle.
- Taken BEQ:
  - Stimulus: rs=rt=5, entradaPC4=0x100, imm=0x10.
  - Response: next cycle PCSrc=1, sinal_deslocado=0x140, both flushes=1.
  - Then one FLUSH cycle (flushes=1, PCSrc=0), then IDLE.
- Not taken:
  - Stimulus: BNE with rs=rt=7.
  - Response: PCSrc stays 0, no flush, busy=0.
- Negative offset and wrap:
  - imm=0xFFFFFFFF, entradaPC4=0x8 -> target 0x4.
  - imm=0x00000001, entradaPC4=0xFFFFFFFC -> target 0x00000000.
- Wrong-path suppression: JMP taken, then JMP with valid_in=1 on the next 2 cycles -> exactly one PCSrc=1 pulse, target from the first jump.
- Stall in REDIRECT: assert stall_in for 3 cycles -> PCSrc=1 and sinal_deslocado constant for 4 cycles total, then FLUSH proceeds normally.
